// File: rtl/four_bit_asy_updown_pkg.sv
// Shared constants and types for the four_bit_asy_updown up/down counter.
// Optional terminal-count output is enabled by FOUR_BIT_ASY_UPDOWN_TC_EN.
package four_bit_asy_updown_pkg;

   localparam int DEFAULT_WIDTH = 4;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : four_bit_asy_updown_pkg

// File: rtl/four_bit_asy_updown_if.sv
// Counter-side signal bundle: direction in, count (and optional tc) out.
// Port tc exists only when FOUR_BIT_ASY_UPDOWN_TC_EN is defined.
interface four_bit_asy_updown_if
   import four_bit_asy_updown_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             up_down;
   logic [WIDTH-1:0] count;
`ifdef FOUR_BIT_ASY_UPDOWN_TC_EN
   logic             tc;

   modport master (output up_down, input count, input tc);
   modport slave  (input up_down, output count, output tc);
`else
   modport master (output up_down, input count);
   modport slave  (input up_down, output count);
`endif

endinterface : four_bit_asy_updown_if

// File: rtl/four_bit_asy_updown_bit_cell.sv
// One counter bit: a toggle flop with synchronous, active-high reset.
module updown_bit_cell (
   input  logic clk,
   input  logic rst,
   input  logic toggle_en,
   output logic q
);

   logic q_d;
   logic q_q;

   // Next-state: invert when enabled, otherwise hold.
   always_comb begin
      q_d = q_q;
      if (toggle_en) begin
         q_d = ~q_q;
      end else begin
         q_d = q_q;
      end
   end

   // State register; reset wins over any toggle request.
   always_ff @(posedge clk) begin
      if (rst) begin
         q_q <= 1'b0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule : updown_bit_cell

// File: rtl/four_bit_asy_updown.sv
// WIDTH-bit synchronous up/down counter built from a toggle-enable chain.
// Define FOUR_BIT_ASY_UPDOWN_TC_EN to add the combinational terminal-count output.
module four_bit_asy_updown
   import four_bit_asy_updown_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   four_bit_asy_updown_if.slave  bus
);

   logic [WIDTH-1:0] q_s;

   // Bit i toggles when all lower bits are 1 (up) or all are 0 (down).
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      logic toggle_en_s;

      if (i == 0) begin : g_lsb
         assign toggle_en_s = 1'b1;
      end else begin : g_upper
         assign toggle_en_s = (bus.up_down == DIR_UP) ? (&q_s[i-1:0])
                                                      : ~(|q_s[i-1:0]);
      end

      updown_bit_cell u_cell (
         .clk       (clk),
         .rst       (rst),
         .toggle_en (toggle_en_s),
         .q         (q_s[i])
      );
   end

   assign bus.count = q_s;

`ifdef FOUR_BIT_ASY_UPDOWN_TC_EN
   logic tc_s;

   // Flags that the next edge wraps in the current direction; forced low in reset.
   always_comb begin
      tc_s = 1'b0;
      if (rst) begin
         tc_s = 1'b0;
      end else if (bus.up_down == DIR_UP) begin
         tc_s = (q_s == {WIDTH{1'b1}});
      end else begin
         tc_s = (q_s == {WIDTH{1'b0}});
      end
   end

   assign bus.tc = tc_s;
`endif

endmodule : four_bit_asy_updown

// File: tb/tb_four_bit_asy_updown.sv
// Self-checking bench: WIDTH=4, 2 and 8 counters share one stimulus stream and
// are compared each cycle against an arithmetic modulo model (tc with FOUR_BIT_ASY_UPDOWN_TC_EN).
module tb_four_bit_asy_updown;
   import four_bit_asy_updown_pkg::*;

   logic clk;
   logic rst;
   logic up_down;

   int errors = 0;
   int checks = 0;

   // index 0: WIDTH=4, 1: WIDTH=2, 2: WIDTH=8
   int modulus [3] = '{16, 4, 256};
   int m [3]       = '{0, 0, 0};
   bit valid       = 1'b0;

   four_bit_asy_updown_if #(.WIDTH(4)) if4 ();
   four_bit_asy_updown_if #(.WIDTH(2)) if2 ();
   four_bit_asy_updown_if #(.WIDTH(8)) if8 ();

   assign if4.up_down = up_down;
   assign if2.up_down = up_down;
   assign if8.up_down = up_down;

   four_bit_asy_updown #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
   four_bit_asy_updown #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
   four_bit_asy_updown #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_tc(input int cnt, input int modv, input logic r, input logic ud);
      if (r) return 0;
      if (ud) return (cnt == modv - 1) ? 1 : 0;
      return (cnt == 0) ? 1 : 0;
   endfunction

   // Reference model: reset to zero, else step by +/-1 modulo 2**WIDTH.
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rst)
            m[k] <= 0;
         else if (up_down)
            m[k] <= (m[k] + 1) % modulus[k];
         else
            m[k] <= (m[k] + modulus[k] - 1) % modulus[k];
      end
      if (rst) valid <= 1'b1;
   end

   // Cycle-by-cycle comparison, away from the active edge.
   always @(negedge clk) begin
      if (valid) begin
         check("cnt_w4", int'(if4.count), m[0]);
         check("cnt_w2", int'(if2.count), m[1]);
         check("cnt_w8", int'(if8.count), m[2]);
`ifdef FOUR_BIT_ASY_UPDOWN_TC_EN
         check("tc_w4", int'(if4.tc), model_tc(m[0], modulus[0], rst, up_down));
         check("tc_w2", int'(if2.tc), model_tc(m[1], modulus[1], rst, up_down));
         check("tc_w8", int'(if8.tc), model_tc(m[2], modulus[2], rst, up_down));
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   int exp_dn [8] = '{5, 4, 3, 2, 1, 0, 15, 14};

   initial begin
      // reset with unknown direction
      rst     = 1'b1;
      up_down = 1'bx;
      tick();
      tick();
      check("rst_cnt_w4", int'(if4.count), 0);
      check("rst_cnt_w2", int'(if2.count), 0);
      check("rst_cnt_w8", int'(if8.count), 0);
      check("rst_no_x", int'($isunknown(if4.count)), 0);

      // count up 1..6
      rst     = 1'b0;
      up_down = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         check("up_seq", int'(if4.count), i);
      end

      // direction switch and down wrap
      up_down = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("down_seq", int'(if4.count), exp_dn[i]);
      end

      // up wrap over 17 edges from 0
      rst = 1'b1;
      tick();
      check("rst_again", int'(if4.count), 0);
      rst     = 1'b0;
      up_down = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         tick();
`ifdef FOUR_BIT_ASY_UPDOWN_TC_EN
         if (i == 14) check("tc_lo_at14", int'(if4.tc), 0);
         if (i == 15) check("tc_hi_at15", int'(if4.tc), 1);
`endif
         if (i == 15) check("upwrap_15", int'(if4.count), 15);
         if (i == 16) check("upwrap_0", int'(if4.count), 0);
      end
      check("upwrap_1", int'(if4.count), 1);
      check("w2_after17", int'(if2.count), 1);
      check("w8_after17", int'(if8.count), 17);

      // mid-count reset
      for (int i = 0; i < 8; i++) tick();
      check("reach_9", int'(if4.count), 9);
      rst = 1'b1;
      tick();
      check("mid_rst", int'(if4.count), 0);
      rst = 1'b0;
      tick();
      check("resume_up", int'(if4.count), 1);
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      up_down = 1'b0;
      tick();
      check("resume_dn_w4", int'(if4.count), 15);
      check("resume_dn_w2", int'(if2.count), 3);
      check("resume_dn_w8", int'(if8.count), 255);

      // width sweep: full up cycle for WIDTH=8
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      up_down = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         tick();
         if (i == 255) check("w8_top", int'(if8.count), 255);
      end
      check("w8_wrap0", int'(if8.count), 0);
      check("w2_wrap0", int'(if2.count), 0);
      check("w4_wrap0", int'(if4.count), 0);
      up_down = 1'b0;
      tick();
      check("w8_dnwrap", int'(if8.count), 255);
      check("w2_dnwrap", int'(if2.count), 3);
      check("w4_dnwrap", int'(if4.count), 15);

      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_four_bit_asy_updown
